int_to_fp_pipe: RTL

INT_TO_FP_PIPE -- requirements
Module: int_to_fp_pipe

---
 rtl/int_to_fp_pipe_pkg.sv | 32 +++
 rtl/int_to_fp_pipe_lzc64.sv | 17 +
 rtl/int_to_fp_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/int_to_fp_pipe_pkg.sv
// Shared constants for the integer-to-floating-point converter.
//   rm_e   : rounding-mode encodings (values 5..7 are treated as RNE)
//   fmt_e  : destination format encodings
//   BIAS_* : exponent biases, MANT_* : stored mantissa widths
//   FFLAG_*: bit positions inside the {NV, DZ, OF, UF, NX} flag vector
package int_to_fp_pipe_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef enum logic {
    FMT_S = 1'b0,
    FMT_D = 1'b1
  } fmt_e;

  localparam int BIAS_S = 127;
  localparam int BIAS_D = 1023;
  localparam int MANT_S = 23;
  localparam int MANT_D = 52;

  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

endpackage

// File: rtl/int_to_fp_pipe_lzc64.sv
// Combinational 64-bit leading-zero counter.
//   val : 64-bit operand
//   cnt : number of leading zeros, 0..64 (64 when val is zero)
module lzc64 (
  input  logic [63:0] val,
  output logic [6:0]  cnt
);

  // Scan upward so the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = 7'd64;
    for (int i = 0; i < 64; i++) begin
      if (val[i]) cnt = 7'(63 - i);
    end
  end

endmodule

// File: rtl/int_to_fp_pipe.sv
// Two-stage integer to IEEE single/double converter with valid/ready flow.
//   clock, reset      : clock, synchronous active-high reset
//   io_in_*           : request (integer, op {long, signed}, fmt, rm)
//   io_flush          : drop everything in flight and the request of this cycle
//   io_out_*          : result (single NaN-boxed) and {NV, DZ, OF, UF, NX}
// S1 holds sign, magnitude and leading-zero count; S2 holds the packed result.
module int_to_fp_pipe
  import int_to_fp_pipe_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [63:0] io_in_int,
  input  logic [1:0]  io_in_op,
  input  logic        io_in_fmt,
  input  logic [2:0]  io_in_rm,
  input  logic        io_flush,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [63:0] io_out_result,
  output logic [4:0]  io_out_fflags
);

  logic        s1_valid, s2_valid, s2_ready;
  logic        s1_sign, s1_fmt;
  logic [2:0]  s1_rm;
  logic [63:0] s1_mag;
  logic [6:0]  s1_lzc;
  logic [63:0] s2_result;
  logic [4:0]  s2_fflags;

  assign s2_ready     = !s2_valid || io_out_ready;
  assign io_in_ready  = !s1_valid || s2_ready;
  assign io_out_valid = s2_valid;
  assign io_out_result = s2_result;
  assign io_out_fflags = s2_fflags;

  // ---------------- S1 input side ----------------
  logic [63:0] src, mag;
  logic        neg;
  logic [6:0]  mag_lzc;

  // 32-bit ops extend from bit 31; the upper input half is ignored.
  assign src = io_in_op[1] ? io_in_int
                           : {{32{io_in_op[0] & io_in_int[31]}}, io_in_int[31:0]};
  assign neg = io_in_op[0] & src[63];
  assign mag = neg ? -src : src;

  lzc64 u_lzc (.val(mag), .cnt(mag_lzc));

  // ---------------- S2 input side: normalise, round, pack ----------------
  logic [63:0]     norm;
  logic            is_zero, lsb, rnd, sticky, inc;
  logic [MANT_D:0] mant_d;
  logic [MANT_S:0] mant_s;
  logic [10:0]     exp_d;
  logic [7:0]      exp_s;
  logic [63:0]     result;
  logic [4:0]      fflags;

  always_comb begin
    norm    = s1_mag << s1_lzc[5:0];
    is_zero = !norm[63];
    if (s1_fmt == FMT_D) begin
      lsb    = norm[11];
      rnd    = norm[10];
      sticky = |norm[9:0];
    end else begin
      lsb    = norm[40];
      rnd    = norm[39];
      sticky = |norm[38:0];
    end
    case (s1_rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sign & (rnd | sticky);
      RM_RUP:  inc = !s1_sign & (rnd | sticky);
      RM_RMM:  inc = rnd;
      default: inc = rnd & (sticky | lsb);
    endcase
    // A carry out of the mantissa leaves its stored bits at zero and bumps
    // the exponent by one.
    mant_d = {1'b0, norm[62:11]} + {{MANT_D{1'b0}}, inc};
    mant_s = {1'b0, norm[62:40]} + {{MANT_S{1'b0}}, inc};
    exp_d  = 11'(BIAS_D + 63) - {4'b0, s1_lzc} + {10'b0, mant_d[MANT_D]};
    exp_s  = 8'(BIAS_S + 63) - {1'b0, s1_lzc} + {7'b0, mant_s[MANT_S]};
    if (s1_fmt == FMT_D)
      result = is_zero ? 64'h0 : {s1_sign, exp_d, mant_d[MANT_D-1:0]};
    else
      result = is_zero ? 64'hFFFF_FFFF_0000_0000
                       : {32'hFFFF_FFFF, s1_sign, exp_s, mant_s[MANT_S-1:0]};
    fflags = '0;
    fflags[FFLAG_NX] = rnd | sticky;
  end

  // ---------------- valid bits ----------------
  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (io_in_ready) s1_valid <= io_in_valid;
      if (s2_ready)    s2_valid <= s1_valid;
    end
  end

  // ---------------- data registers (unreset) ----------------
  always_ff @(posedge clock) begin
    if (io_in_valid && io_in_ready) begin
      s1_sign <= neg;
      s1_mag  <= mag;
      s1_lzc  <= mag_lzc;
      s1_fmt  <= io_in_fmt;
      s1_rm   <= io_in_rm;
    end
    if (s1_valid && s2_ready) begin
      s2_result <= result;
      s2_fflags <= fflags;
    end
  end

endmodule
